// File: rtl/key_debounce.sv
// Pushbutton synchronizer and debouncer with clean level and press/release pulses.
// Optional auto-repeat of key_press while held: define REPEAT_EN.
module key_debounce #(
    parameter int N        = 4,
    parameter int DIV      = 250000,
    parameter int STABLE   = 4,
    parameter int RPT_DLY  = 100,
    parameter int RPT_RATE = 20
) (
    input  logic         ck,
    input  logic         rs,
    input  logic [N-1:0] key_n,
    output logic [N-1:0] key_level,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (STABLE > 0) ? $clog2(STABLE + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] STB      = CW'(STABLE);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PWAIT = 2'd1,
        HELD  = 2'd2,
        RWAIT = 2'd3
    } st_t;

    logic [N-1:0]  sync1_q, sync1_d;
    logic [N-1:0]  sync2_q, sync2_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic [N-1:0]  s;

    st_t           state_q [N];
    st_t           state_d [N];
    logic [CW-1:0] cnt_q   [N];
    logic [CW-1:0] cnt_d   [N];
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  rel_q, rel_d;

`ifdef REPEAT_EN
    localparam int RMAX = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DLY  = RW'(RPT_DLY);
    localparam logic [RW-1:0] R_RATE = RW'(RPT_RATE);
    localparam logic [RW-1:0] R_ONE  = RW'(1);

    logic [RW-1:0] rpt_q [N];
    logic [RW-1:0] rpt_d [N];
    logic [N-1:0]  rfast_q, rfast_d;
    logic [RW-1:0] rpt_nxt;
`endif

    assign tick = (div_q == DIV_LAST);
    assign s    = ~sync2_q;

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = rel_q;

    // Synchronizer shift and free-running sample divider.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        div_d   = tick ? '0 : div_q + DW'(1);
    end

    // Synchronizer and divider registers; keys read as released out of reset.
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            sync1_q <= '1;
            sync2_q <= '1;
            div_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            div_q   <= div_d;
        end
    end

    // Per-key debounce FSM, advanced only on sample ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
`ifdef REPEAT_EN
        rpt_d   = rpt_q;
        rfast_d = rfast_q;
        rpt_nxt = '0;
`endif
        for (int i = 0; i < N; i++) begin
            if (tick) begin
                unique case (state_q[i])
                    IDLE: begin
                        if (s[i]) begin
                            if (STABLE <= 1) begin
                                state_d[i] = HELD;
                                cnt_d[i]   = '0;
                                level_d[i] = 1'b1;
                                press_d[i] = 1'b1;
`ifdef REPEAT_EN
                                rpt_d[i]   = '0;
                                rfast_d[i] = 1'b0;
`endif
                            end else begin
                                state_d[i] = PWAIT;
                                cnt_d[i]   = C_ONE;
                            end
                        end
                    end
                    PWAIT: begin
                        if (!s[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] + C_ONE >= STB) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = '0;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
`ifdef REPEAT_EN
                            rpt_d[i]   = '0;
                            rfast_d[i] = 1'b0;
`endif
                        end else begin
                            cnt_d[i] = cnt_q[i] + C_ONE;
                        end
                    end
                    HELD: begin
                        if (!s[i]) begin
                            if (STABLE <= 1) begin
                                state_d[i] = IDLE;
                                cnt_d[i]   = '0;
                                level_d[i] = 1'b0;
                                rel_d[i]   = 1'b1;
                            end else begin
                                state_d[i] = RWAIT;
                                cnt_d[i]   = C_ONE;
                            end
                        end else begin
`ifdef REPEAT_EN
                            rpt_nxt = rpt_q[i] + R_ONE;
                            if (rpt_nxt == (rfast_q[i] ? R_RATE : R_DLY)) begin
                                press_d[i] = 1'b1;
                                rpt_d[i]   = '0;
                                rfast_d[i] = 1'b1;
                            end else begin
                                rpt_d[i] = rpt_nxt;
                            end
`endif
                        end
                    end
                    RWAIT: begin
                        if (s[i]) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = '0;
`ifdef REPEAT_EN
                            rpt_d[i]   = '0;
                            rfast_d[i] = 1'b0;
`endif
                        end else if (cnt_q[i] + C_ONE >= STB) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                            level_d[i] = 1'b0;
                            rel_d[i]   = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + C_ONE;
                        end
                    end
                endcase
            end
        end
    end

    // Per-key state, counters and registered outputs.
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
`ifdef REPEAT_EN
                rpt_q[i]   <= '0;
`endif
            end
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
`ifdef REPEAT_EN
            rfast_q <= '0;
`endif
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef REPEAT_EN
                rpt_q[i]   <= rpt_d[i];
`endif
            end
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
`ifdef REPEAT_EN
            rfast_q <= rfast_d;
`endif
        end
    end

endmodule
